// File: rtl/ddr_tx_pkg.sv
// -----------------------------------------------------------------------------
// ddr_tx_pkg
// Shared constants, sample type and frame-geometry helpers for the DDR
// transmit gearbox and the lane/slot reorder network.
//
// Contents:
//   *_DEF               default SAMPLE_W / IN_WORDS / NUM_CH / SER_FACTOR
//   sample_t            one sample at the default width
//   frame_len()         samples per output frame (lanes * slots)
//   beats_per_frame()   input beats needed to fill one frame
// -----------------------------------------------------------------------------
package ddr_tx_pkg;

  localparam int SAMPLE_W_DEF   = 14;
  localparam int IN_WORDS_DEF   = 5;
  localparam int NUM_CH_DEF     = 2;
  localparam int SER_FACTOR_DEF = 10;

  typedef logic [SAMPLE_W_DEF-1:0] sample_t;

  function automatic int frame_len(input int num_ch, input int ser_factor);
    return num_ch * ser_factor;
  endfunction

  function automatic int beats_per_frame(input int num_ch, input int ser_factor,
                                         input int in_words);
    return (num_ch * ser_factor) / in_words;
  endfunction

endpackage

// File: rtl/ddr_tx_lane_map.sv
// -----------------------------------------------------------------------------
// ddr_tx_lane_map
// Purely combinational reorder from arrival order to lane/slot order.
// Flat sample k (k*SAMPLE_W in i_flat) lands on lane k%NUM_CH, slot
// k/NUM_CH, i.e. at offset (lane*SER_FACTOR+slot)*SAMPLE_W in o_lanes.
// Slot 0 is the first one serialised. Shared with the receive side.
//
// Ports:
//   i_flat   in   NUM_CH*SER_FACTOR*SAMPLE_W  samples in arrival order
//   o_lanes  out  NUM_CH*SER_FACTOR*SAMPLE_W  samples grouped per lane
// -----------------------------------------------------------------------------
module ddr_tx_lane_map
  import ddr_tx_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int SER_FACTOR = SER_FACTOR_DEF
) (
  input  logic [NUM_CH*SER_FACTOR*SAMPLE_W-1:0] i_flat,
  output logic [NUM_CH*SER_FACTOR*SAMPLE_W-1:0] o_lanes
);

  localparam int FRAME = frame_len(NUM_CH, SER_FACTOR);

  for (genvar k = 0; k < FRAME; k++) begin : g_map
    localparam int LANE = k % NUM_CH;
    localparam int SLOT = k / NUM_CH;
    assign o_lanes[(LANE*SER_FACTOR+SLOT)*SAMPLE_W +: SAMPLE_W] =
           i_flat[k*SAMPLE_W +: SAMPLE_W];
  end

endmodule

// File: rtl/ddr_tx_gearbox.sv
// -----------------------------------------------------------------------------
// ddr_tx_gearbox
// Packs IN_WORDS-sample input beats into NUM_CH x SER_FACTOR sample frames
// for the per-lane DDR serializers. A fill register collects BEATS beats;
// the completed frame is reordered into lane/slot order and moved into a
// hold register that drives out_data under valid/ready.
//
// Ports:
//   clk           in   sole clock
//   reset_n       in   asynchronous active-low reset
//   align         in   synchronous frame-phase restart (drops partial fill)
//   in_data       in   IN_WORDS samples, sample 0 in the LSBs
//   in_valid      in   input beat present
//   in_ready      out  beat can be accepted
//   out_data      out  lane c, slot s at (c*SER_FACTOR+s)*SAMPLE_W
//   out_valid     out  frame present
//   out_ready     in   consumer takes frame
//   frame_phase   out  beats accumulated in the current frame
//   overflow      out  sticky: beat offered while in_ready low (not in align)
//   test_en       in   (DDR_TX_GEARBOX_TESTPAT_EN only) replace beats by ramp
//   overflow_clr  in   synchronous clear of overflow, wins over a set
//
// Build option: define DDR_TX_GEARBOX_TESTPAT_EN to add the test_en ramp
// generator. Without it in_data is always used.
// -----------------------------------------------------------------------------
module ddr_tx_gearbox
  import ddr_tx_pkg::*;
#(
  parameter  int SAMPLE_W   = SAMPLE_W_DEF,
  parameter  int IN_WORDS   = IN_WORDS_DEF,
  parameter  int NUM_CH     = NUM_CH_DEF,
  parameter  int SER_FACTOR = SER_FACTOR_DEF,
  localparam int FRAME      = frame_len(NUM_CH, SER_FACTOR),
  localparam int BEATS      = beats_per_frame(NUM_CH, SER_FACTOR, IN_WORDS),
  localparam int PH_W       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         align,
  input  logic [IN_WORDS*SAMPLE_W-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [FRAME*SAMPLE_W-1:0]    out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PH_W-1:0]              frame_phase,
  output logic                         overflow,
`ifdef DDR_TX_GEARBOX_TESTPAT_EN
  input  logic                         test_en,
`endif
  input  logic                         overflow_clr
);

  localparam int              BEAT_W  = IN_WORDS * SAMPLE_W;
  localparam int              FRAME_W = FRAME * SAMPLE_W;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(BEATS - 1);

  // A frame must be an exact, non-zero number of input beats.
  if (((FRAME % IN_WORDS) != 0) || (BEATS < 1)) begin : g_bad_ratio
    $error("ddr_tx_gearbox: NUM_CH*SER_FACTOR must be a non-zero multiple of IN_WORDS");
  end

  logic [FRAME_W-1:0] r_fill;
  logic [FRAME_W-1:0] r_hold;
  logic [PH_W-1:0]    r_phase;
  logic               r_pending;     // completed frame in r_fill waiting for hold
  logic               r_out_valid;
  logic               r_overflow;

  logic [BEAT_W-1:0]  w_beat;
  logic [FRAME_W-1:0] w_fill_next;
  logic [FRAME_W-1:0] w_hold_src;
  logic [FRAME_W-1:0] w_hold_mapped;
  logic               w_hold_free;
  logic               w_accept;
  logic               w_complete;
  logic               w_load_hold;

  // ---------------------------------------------------------------------------
  // Beat source: live samples, or the ramp generator when built in.
  // ---------------------------------------------------------------------------
`ifdef DDR_TX_GEARBOX_TESTPAT_EN
  logic [SAMPLE_W-1:0] r_ramp;

  always_comb begin
    w_beat = in_data;
    if (test_en) begin
      for (int i = 0; i < IN_WORDS; i++) begin
        w_beat[i*SAMPLE_W +: SAMPLE_W] = r_ramp + SAMPLE_W'(i);
      end
    end
  end

  // Wraps modulo 2^SAMPLE_W by construction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ramp <= '0;
    end else if (align) begin
      r_ramp <= '0;
    end else if (w_accept && test_en) begin
      r_ramp <= r_ramp + SAMPLE_W'(IN_WORDS);
    end
  end
`else
  assign w_beat = in_data;
`endif

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign w_hold_free = !r_out_valid || out_ready;
  // Input stalls only while a finished frame cannot move into hold.
  assign in_ready    = !align && !(r_pending && !w_hold_free);
  assign w_accept    = in_valid && in_ready;
  assign w_complete  = w_accept && (r_phase == LAST_PH);
  assign w_load_hold = w_hold_free && (r_pending || w_complete);
  // A waiting frame always goes first; otherwise the frame finishing this
  // cycle is taken straight from the merged fill so out_valid follows the
  // last accept by one clock.
  assign w_hold_src  = r_pending ? r_fill : w_fill_next;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_fill_next = r_fill;
    for (int b = 0; b < BEATS; b++) begin
      if (r_phase == PH_W'(b)) begin
        w_fill_next[b*BEAT_W +: BEAT_W] = w_beat;
      end
    end
  end

  ddr_tx_lane_map #(
    .SAMPLE_W   (SAMPLE_W),
    .NUM_CH     (NUM_CH),
    .SER_FACTOR (SER_FACTOR)
  ) u_lane_map (
    .i_flat  (w_hold_src),
    .o_lanes (w_hold_mapped)
  );

  // ---------------------------------------------------------------------------
  // Fill side
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the fill register is wide but still reset, so a frame started
      // after reset never exposes stale samples.
      r_fill    <= '0;
      r_phase   <= '0;
      r_pending <= 1'b0;
    end else begin
      // in_ready is low during align, so no beat is written in that cycle.
      if (w_accept) begin
        r_fill <= w_fill_next;
      end

      if (align) begin
        r_phase <= '0;
      end else if (w_accept) begin
        r_phase <= (r_phase == LAST_PH) ? '0 : r_phase + 1'b1;
      end

      // A completed frame is never discarded by align; only the partial
      // fill (tracked by r_phase) is.
      if (r_pending) begin
        r_pending <= !w_hold_free || w_complete;
      end else begin
        r_pending <= w_complete && !w_hold_free;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hold side
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold      <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load_hold) begin
      r_hold      <= w_hold_mapped;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (overflow_clr) begin
      r_overflow <= 1'b0;
    end else if (in_valid && !in_ready && !align) begin
      r_overflow <= 1'b1;
    end
  end

  assign out_data    = r_hold;
  assign out_valid   = r_out_valid;
  assign frame_phase = r_phase;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_ddr_tx_gearbox.sv
// -----------------------------------------------------------------------------
// tb_ddr_tx_gearbox
// Scoreboard bench for ddr_tx_gearbox. Accepted beats feed a sample model;
// each completed frame is pushed as an expected out_data word and popped by
// a monitor when the DUT hands a frame over. A second instance checks the
// 4-word / 4-lane / 8-slot geometry. With DDR_TX_GEARBOX_TESTPAT_EN defined
// the ramp generator is also exercised across its wrap.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ddr_tx_gearbox;
  import ddr_tx_pkg::*;

  localparam int SW  = 14;
  localparam int IW  = 5;
  localparam int NC  = 2;
  localparam int SF  = 10;
  localparam int FR  = NC * SF;
  localparam int BT  = FR / IW;
  localparam int FW  = FR * SW;
  localparam int PHW = 2;

  localparam int IW2  = 4;
  localparam int NC2  = 4;
  localparam int SF2  = 8;
  localparam int FR2  = NC2 * SF2;
  localparam int BT2  = FR2 / IW2;
  localparam int FW2  = FR2 * SW;
  localparam int PHW2 = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           align = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic           overflow_clr = 1'b0;
  logic [IW*SW-1:0] in_data = '0;
  logic           in_ready;
  logic           out_valid;
  logic           overflow;
  logic [FW-1:0]  out_data;
  logic [PHW-1:0] frame_phase;
`ifdef DDR_TX_GEARBOX_TESTPAT_EN
  logic           test_en = 1'b0;
  logic           b_test_en = 1'b0;
`endif

  logic             b_align = 1'b0;
  logic             b_in_valid = 1'b0;
  logic             b_out_ready = 1'b1;
  logic             b_clr = 1'b0;
  logic [IW2*SW-1:0] b_in_data = '0;
  logic             b_in_ready;
  logic             b_out_valid;
  logic             b_overflow;
  logic [FW2-1:0]   b_out_data;
  logic [PHW2-1:0]  b_frame_phase;

  always #5 clk = ~clk;

  ddr_tx_gearbox dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .align        (align),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .frame_phase  (frame_phase),
    .overflow     (overflow),
`ifdef DDR_TX_GEARBOX_TESTPAT_EN
    .test_en      (test_en),
`endif
    .overflow_clr (overflow_clr)
  );

  ddr_tx_gearbox #(
    .SAMPLE_W   (SW),
    .IN_WORDS   (IW2),
    .NUM_CH     (NC2),
    .SER_FACTOR (SF2)
  ) dut_alt (
    .clk          (clk),
    .reset_n      (reset_n),
    .align        (b_align),
    .in_data      (b_in_data),
    .in_valid     (b_in_valid),
    .in_ready     (b_in_ready),
    .out_data     (b_out_data),
    .out_valid    (b_out_valid),
    .out_ready    (b_out_ready),
    .frame_phase  (b_frame_phase),
    .overflow     (b_overflow),
`ifdef DDR_TX_GEARBOX_TESTPAT_EN
    .test_en      (b_test_en),
`endif
    .overflow_clr (b_clr)
  );

  int            total = 0;
  int            bad = 0;
  logic [FW-1:0] exp_q[$];
  sample_t       m_samples[$];
  int            next_sample = 0;
  sample_t       m_ramp = '0;
  bit            tp_mode = 1'b0;
  bit            mon_en = 1'b0;

  // Expected frame from the accepted samples: sample k -> lane k%NC, slot k/NC.
  function automatic logic [FW-1:0] build_frame();
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < FR; k++) begin
      f[((k % NC) * SF + k / NC) * SW +: SW] = m_samples[k];
    end
    return f;
  endfunction

  // Offer one beat for one clock; exp_acc is the model's in_ready for it.
  task automatic drive_beat(input bit exp_acc, input string tag);
    sample_t w[IW];
    for (int i = 0; i < IW; i++) begin
      w[i] = tp_mode ? sample_t'(m_ramp + sample_t'(i)) : sample_t'(next_sample + i);
      in_data[i*SW +: SW] = tp_mode ? sample_t'($urandom) : w[i];
    end
    in_valid = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== exp_acc) begin
      bad++;
      $display("FAIL %s in_ready: got %b want %b", tag, in_ready, exp_acc);
    end
    @(posedge clk);
    if (exp_acc) begin
      for (int i = 0; i < IW; i++) m_samples.push_back(w[i]);
      if (tp_mode) m_ramp = m_ramp + sample_t'(IW);
      else         next_sample = next_sample + IW;
      if (m_samples.size() == FR) begin
        exp_q.push_back(build_frame());
        m_samples.delete();
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame monitor: compares every presented frame with the scoreboard head
  // (also covers stability while stalled) and retires it on handover.
  always @(negedge clk) begin
    if (mon_en && reset_n && out_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL mon_frame: out_valid=1 got %h want no frame", out_data);
      end else begin
        if (out_data !== exp_q[0]) begin
          bad++;
          $display("FAIL mon_frame: got %h want %h", out_data, exp_q[0]);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_drained(input string tag);
    total++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s drained: got pending=%0d out_valid=%b want 0 0", tag, exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || frame_phase !== '0 ||
        overflow !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got v=%b d=%h ph=%0d ov=%b rdy=%b want 0 0 0 0 1",
               out_valid, out_data, frame_phase, overflow, in_ready);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || frame_phase !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: got v=%b ph=%0d rdy=%b want 0 0 1", out_valid, frame_phase, in_ready);
    end
  endtask

  task automatic test_stream();
    logic [FW-1:0] exp_lanes;
    out_ready = 1'b1;
    for (int b = 0; b < BT; b++) begin
      drive_beat(1'b1, "stream");
      if (b == 1) begin
        total++;
        if (frame_phase !== 2'd2) begin
          bad++;
          $display("FAIL stream_phase: got %0d want 2", frame_phase);
        end
      end
      if (b < BT - 1) begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL stream_early_valid: got %b want 0", out_valid);
        end
      end
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL stream_latency: out_valid got %b want 1", out_valid);
    end
    // Samples 0..19: lane c slot s carries s*NC+c.
    exp_lanes = '0;
    for (int c = 0; c < NC; c++)
      for (int s = 0; s < SF; s++)
        exp_lanes[(c * SF + s) * SW +: SW] = sample_t'(s * NC + c);
    total++;
    if (out_data !== exp_lanes) begin
      bad++;
      $display("FAIL stream_lanes: got %h want %h", out_data, exp_lanes);
    end
    idle(2);
    check_drained("stream");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int b = 0; b < 2 * BT; b++) drive_beat(1'b1, "bp_fill");
    total++;
    if (overflow !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_full: got ov=%b v=%b want 0 1", overflow, out_valid);
    end
    drive_beat(1'b0, "bp_stall");
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL bp_overflow_set: got %b want 1", overflow);
    end
    drive_beat(1'b0, "bp_stall2");
    in_valid = 1'b0;
    overflow_clr = 1'b1;
    @(posedge clk); #1;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL bp_overflow_clr: got %b want 0", overflow);
    end
    // Clear and a new offered beat in the same cycle: clear wins.
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    overflow_clr = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL bp_clr_priority: got %b want 0", overflow);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_no_gap: got v=%b rdy=%b want 1 1", out_valid, in_ready);
    end
    idle(2);
    check_drained("backpressure");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int b = 0; b < 3 * BT; b++) drive_beat(1'b1, "b2b");
    idle(2);
    check_drained("back_to_back");
  endtask

  task automatic test_align();
    out_ready = 1'b1;
    drive_beat(1'b1, "al_pre");
    drive_beat(1'b1, "al_pre");
    total++;
    if (frame_phase !== 2'd2) begin
      bad++;
      $display("FAIL align_pre_phase: got %0d want 2", frame_phase);
    end
    align = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL align_in_ready: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    align = 1'b0;
    in_valid = 1'b0;
    m_samples.delete();
    total++;
    if (frame_phase !== '0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL align_post: got ph=%0d ov=%b want 0 0", frame_phase, overflow);
    end
    for (int b = 0; b < BT; b++) drive_beat(1'b1, "al_post");
    idle(2);
    check_drained("align");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int b = 0; b < 2 * BT; b++) drive_beat(1'b1, "rst_fill");
    drive_beat(1'b0, "rst_stall");
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) drive_beat(1'b1, "rst_part");
    in_valid = 1'b0;
    total++;
    if (frame_phase !== 2'd3 || out_valid !== 1'b1 || overflow !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre: got ph=%0d v=%b ov=%b want 3 1 1", frame_phase, out_valid, overflow);
    end
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    m_samples.delete();
    total++;
    if (out_valid !== 1'b0 || frame_phase !== '0 || overflow !== 1'b0 || out_data !== '0) begin
      bad++;
      $display("FAIL rst_async: got v=%b ph=%0d ov=%b d=%h want 0 0 0 0",
               out_valid, frame_phase, overflow, out_data);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int b = 0; b < BT; b++) drive_beat(1'b1, "rst_post");
    idle(2);
    check_drained("reset_mid");
  endtask

  task automatic test_alt_geometry();
    logic [FW2-1:0] exp_alt;
    b_out_ready = 1'b1;
    for (int b = 0; b < BT2; b++) begin
      for (int i = 0; i < IW2; i++) b_in_data[i*SW +: SW] = sample_t'(1000 + b * IW2 + i);
      b_in_valid = 1'b1;
      @(negedge clk);
      total++;
      if (b_in_ready !== 1'b1) begin
        bad++;
        $display("FAIL alt_in_ready: got %b want 1", b_in_ready);
      end
      @(posedge clk); #1;
      if (b < BT2 - 1) begin
        total++;
        if (b_out_valid !== 1'b0) begin
          bad++;
          $display("FAIL alt_early_valid: got %b want 0", b_out_valid);
        end
      end
    end
    b_in_valid = 1'b0;
    exp_alt = '0;
    for (int c = 0; c < NC2; c++)
      for (int s = 0; s < SF2; s++)
        exp_alt[(c * SF2 + s) * SW +: SW] = sample_t'(1000 + s * NC2 + c);
    total++;
    if (b_out_valid !== 1'b1 || b_out_data !== exp_alt) begin
      bad++;
      $display("FAIL alt_frame: got v=%b d=%h want 1 %h", b_out_valid, b_out_data, exp_alt);
    end
    @(posedge clk); #1;
    total++;
    if (b_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL alt_drop: got %b want 0", b_out_valid);
    end
  endtask

`ifdef DDR_TX_GEARBOX_TESTPAT_EN
  task automatic test_testpat();
    out_ready = 1'b1;
    test_en = 1'b1;
    align = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    align = 1'b0;
    tp_mode = 1'b1;
    m_ramp = '0;
    m_samples.delete();
    // 3300 beats = 16500 ramp values, so the 14-bit ramp wraps to 0.
    for (int b = 0; b < 3300; b++) drive_beat(1'b1, "testpat");
    idle(2);
    check_drained("testpat");
    tp_mode = 1'b0;
    test_en = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_align();
    test_reset_mid();
    test_alt_geometry();
`ifdef DDR_TX_GEARBOX_TESTPAT_EN
    test_testpat();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
